// File: rtl/apb_slave_pkg.sv
// Shared types and defaults for the APB register-bank completer.
// No logic beyond a tiny decode helper; no latency or backpressure of its own.
package apb_slave_pkg;

    localparam int          APB_ADDR_W_DEF  = 16;
    localparam int          APB_DATA_W_DEF  = 32;
    localparam int          NUM_REGS_DEF    = 16;
    localparam logic [31:0] ID_VALUE_DEF    = 32'hA9B0_0001;
    localparam int          WAIT_CYCLES_DEF = 2;

    typedef logic [3:0] wait_cnt_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_state_t;

    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Word register bank with read-only ID at index 0; combinational read and error decode,
// write lands on the pclk edge when we=1; never stalls.
module apb_slave_regfile
    import apb_slave_pkg::*;
#(
    parameter int          ADDR_W   = APB_ADDR_W_DEF,
    parameter int          DATA_W   = APB_DATA_W_DEF,
    parameter int          NUM_REGS = NUM_REGS_DEF,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEF
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              we,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              err
);

    localparam int IDX_W = ADDR_W - 2;

    logic [IDX_W-1:0]  idx;
    logic [31:0]       idx_ext;
    logic              out_of_range;
    logic              read_only;
    logic [DATA_W-1:0] regs [1:NUM_REGS-1];

    assign idx          = addr[ADDR_W-1:2];
    assign idx_ext      = 32'(idx);
    assign out_of_range = idx_ext >= 32'(NUM_REGS);
    assign read_only    = wr && (idx == '0);
    assign err          = addr_misaligned(addr[1:0]) | out_of_range | read_only;

    always_comb begin
        rdata = '0;
        if (idx == '0) begin
            rdata = DATA_W'(ID_VALUE);
        end
        for (int k = 1; k < NUM_REGS; k++) begin
            if (idx_ext == 32'(k)) begin
                rdata = regs[k];
            end
        end
    end

    // The caller only raises we for decoded-legal addresses, so idx is in range here.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                regs[k] <= '0;
            end
        end else if (we) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                if (idx_ext == 32'(k)) begin
                    regs[k] <= wdata;
                end
            end
        end
    end

endmodule

// File: rtl/apb_slave_regs.sv
// APB completer over a register bank: 1 setup + (WAIT_CYCLES+1) access cycles, pready low while waiting;
// APB_SLAVE_WAIT_STATES_EN enables the wait counter, otherwise every access completes in its first cycle.
module apb_slave_regs
    import apb_slave_pkg::*;
#(
    parameter int          APB_MAX_ADDRESS_WIDTH = APB_ADDR_W_DEF,
    parameter int          APB_MAX_DATA_WIDTH    = APB_DATA_W_DEF,
    parameter int          NUM_REGS              = NUM_REGS_DEF,
    parameter logic [31:0] ID_VALUE              = ID_VALUE_DEF,
    parameter int          WAIT_CYCLES           = WAIT_CYCLES_DEF
) (
    input  logic                             pclk,
    input  logic                             preset,
    input  logic                             psel,
    input  logic                             penable,
    input  logic                             pwrite,
    input  logic [APB_MAX_ADDRESS_WIDTH-1:0] paddr,
    input  logic [APB_MAX_DATA_WIDTH-1:0]    pwdata,
    output logic                             pready,
    output logic [APB_MAX_DATA_WIDTH-1:0]    prdata,
    output logic                             pslverr
);

    apb_state_t                    state;
    logic                          access_cyc;
    logic                          complete;
    logic                          viol;
    logic                          reg_err;
    logic                          reg_we;
    logic [APB_MAX_DATA_WIDTH-1:0] reg_rdata;

    // SETUP is the state latched by the bus setup cycle, so it also serves as the first access cycle.
    assign access_cyc = psel & penable & (state != IDLE);
    assign viol       = psel & penable & (state == IDLE);

`ifdef APB_SLAVE_WAIT_STATES_EN
    wait_cnt_t wait_cnt;

    assign complete = access_cyc & (wait_cnt == '0);

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel & ~penable) begin
                        state    <= SETUP;
                        wait_cnt <= wait_cnt_t'(WAIT_CYCLES);
                    end
                end
                SETUP, ACCESS: begin
                    if (!psel) begin
                        state <= IDLE;
                    end else if (!penable) begin
                        state    <= SETUP;
                        wait_cnt <= wait_cnt_t'(WAIT_CYCLES);
                    end else if (wait_cnt != '0) begin
                        state    <= ACCESS;
                        wait_cnt <= wait_cnt - 1'b1;
                    end else begin
                        // A back-to-back setup is picked up from IDLE on the next cycle.
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_wait;

    assign unused_wait = ^wait_cnt_t'(WAIT_CYCLES);
    assign complete    = access_cyc;

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (psel & ~penable) begin
                        state <= SETUP;
                    end
                end
                SETUP, ACCESS: begin
                    if (psel & ~penable) begin
                        state <= SETUP;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

    assign reg_we = complete & pwrite & ~reg_err;

    apb_slave_regfile #(
        .ADDR_W   (APB_MAX_ADDRESS_WIDTH),
        .DATA_W   (APB_MAX_DATA_WIDTH),
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VALUE)
    ) u_regfile (
        .pclk   (pclk),
        .preset (preset),
        .we     (reg_we),
        .wr     (pwrite),
        .addr   (paddr),
        .wdata  (pwdata),
        .rdata  (reg_rdata),
        .err    (reg_err)
    );

    // Gated by preset so a reset landing mid-access drops the response in the same cycle.
    assign pready  = ~preset & (complete | viol);
    assign pslverr = ~preset & (viol | (complete & reg_err));
    assign prdata  = (~preset & complete & ~reg_err) ? reg_rdata : '0;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Randomized APB traffic against a behavioural register model; a monitor checks every response.
module tb_apb_slave_regs;

    localparam int          NREGS = 16;
    localparam int          WAITS = 2;
    localparam logic [31:0] ID    = 32'hA9B0_0001;
`ifdef APB_SLAVE_WAIT_STATES_EN
    localparam int EXP_WAITS = WAITS;
`else
    localparam int EXP_WAITS = 0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
        int          tag;
    } exp_t;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    exp_t        exp_q[$];
    logic [31:0] mregs [NREGS];
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;
    int          tag_n  = 0;

    apb_slave_regs #(
        .APB_MAX_ADDRESS_WIDTH (16),
        .APB_MAX_DATA_WIDTH    (32),
        .NUM_REGS              (NREGS),
        .ID_VALUE              (ID),
        .WAIT_CYCLES           (WAITS)
    ) dut (
        .pclk    (pclk),
        .preset  (preset),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pready  (pready),
        .prdata  (prdata),
        .pslverr (pslverr)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic cmp(input string nm, input int tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s #%0d: got %h, expected %h", nm, tag, got, want);
        end
    endtask

    task automatic idle();
        psel    = 1'b0;
        penable = 1'b0;
        @(posedge pclk); #1;
    endtask

    // Full transfer; returns one cycle after completion with psel still high (caller decides back-to-back).
    task automatic xfer(input logic wr, input logic [15:0] a, input logic [31:0] d);
        int          idx;
        int          n;
        logic        err;
        logic [31:0] rd;
        exp_t        e;
        idx = int'(a[15:2]);
        err = (a[1:0] != 2'b00) || (idx >= NREGS) || (wr && idx == 0);
        rd  = 32'h0;
        if (!err) rd = (idx == 0) ? ID : mregs[idx];
        if (!err && wr) mregs[idx] = d;
        e = '{data: rd, err: err, cyc: cyc + 1 + EXP_WAITS, tag: tag_n};
        tag_n++;
        exp_q.push_back(e);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        n = 0;
        forever begin
            @(negedge pclk);
            if (pready) break;
            n++;
            if (n > 40) begin
                cmp("pready_timeout", e.tag, 32'(pready), 32'd1);
                break;
            end
        end
        @(posedge pclk); #1;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge pclk);
            if (!preset) begin
                if (pready) begin
                    if (exp_q.size() == 0) begin
                        cmp("unexpected_pready", -1, 32'(pready), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        cmp("prdata", e.tag, prdata, e.data);
                        cmp("pslverr", e.tag, 32'(pslverr), 32'(e.err));
                        cmp("done_cycle", e.tag, cyc, e.cyc);
                    end
                end else begin
                    cmp("idle_pslverr", -1, 32'(pslverr), 32'd0);
                    cmp("idle_prdata", -1, prdata, 32'd0);
                end
            end
        end
    end

    initial begin
        logic [15:0] a;
        exp_t        e;
        for (int k = 0; k < NREGS; k++) mregs[k] = 32'h0;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        repeat (2) @(posedge pclk);
        #1;
        cmp("rst_pready", 0, 32'(pready), 32'd0);
        cmp("rst_prdata", 0, prdata, 32'd0);
        cmp("rst_pslverr", 0, 32'(pslverr), 32'd0);
        preset = 1'b0;
        @(posedge pclk); #1;

        xfer(1'b1, 16'h0004, 32'hDEADBEEF); idle();
        xfer(1'b0, 16'h0004, 32'h0);        idle();
        xfer(1'b0, 16'h0000, 32'h0);        idle();
        xfer(1'b1, 16'h0000, 32'h12345678); idle();
        xfer(1'b0, 16'h0000, 32'h0);        idle();
        xfer(1'b1, 16'h0040, 32'h11111111); idle();
        xfer(1'b1, 16'h0006, 32'h22222222); idle();
        xfer(1'b0, 16'h0004, 32'h0);        idle();
        xfer(1'b1, 16'h0008, 32'hA5A5_0008);
        xfer(1'b1, 16'h000C, 32'h5A5A_000C); idle();
        xfer(1'b0, 16'h0008, 32'h0);
        xfer(1'b0, 16'h000C, 32'h0);        idle();

        // Abort: psel falls before completion, nothing may respond or commit.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0010; pwdata = 32'hBAD0_0010;
        @(posedge pclk); #1;
        if (EXP_WAITS >= 1) begin
            penable = 1'b1;
            @(posedge pclk); #1;
        end
        idle();
        xfer(1'b0, 16'h0010, 32'h0); idle();

        // Access phase without a setup cycle.
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 16'h0008; pwdata = 32'hFFFF_FFFF;
        e = '{data: 32'h0, err: 1'b1, cyc: cyc, tag: tag_n};
        tag_n++;
        exp_q.push_back(e);
        @(posedge pclk); #1;
        idle();
        xfer(1'b0, 16'h0008, 32'h0); idle();

        // Reset pulse in the access phase of a write.
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0010; pwdata = 32'h5555_5555;
        @(posedge pclk); #1;
        penable = 1'b1;
        #2 preset = 1'b1;
        #1;
        cmp("midrst_pready", 0, 32'(pready), 32'd0);
        cmp("midrst_prdata", 0, prdata, 32'd0);
        cmp("midrst_pslverr", 0, 32'(pslverr), 32'd0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        for (int k = 0; k < NREGS; k++) mregs[k] = 32'h0;
        @(posedge pclk); #1;
        xfer(1'b0, 16'h0010, 32'h0); idle();
        xfer(1'b0, 16'h0004, 32'h0); idle();
        xfer(1'b0, 16'h0000, 32'h0); idle();

        for (int i = 0; i < 80; i++) begin
            a = 16'($urandom_range(0, 19) * 4);
            if ($urandom_range(0, 5) == 0) a = a + 16'($urandom_range(1, 3));
            xfer(1'($urandom_range(0, 1)), a, $urandom);
            if ($urandom_range(0, 1) == 0) idle();
        end

        repeat (4) idle();
        cmp("queue_left", 0, 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
